// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: steps the fetch PC through a combinational ROM,
// queues returned words in a small prefetch buffer and hands them to decode.
module fetch_ctrl #(
  parameter int A        = 8,
  parameter int W_INST   = 32,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = 0
) (
  input  logic                       refresh_clk,
  input  logic                       reset,
  input  logic                       enable_i,
  output logic [A-1:0]               rom_addr_o,
  input  logic [W_INST-1:0]          rom_data_i,
  output logic                       inst_valid_o,
  output logic [W_INST-1:0]          inst_o,
  output logic [A-1:0]               pc_o,
  input  logic                       inst_ready_i,
  input  logic                       redirect_i,
  input  logic [A-1:0]               redirect_pc_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [A-1:0]      fetch_pc;
  logic [CW-1:0]     count;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [W_INST-1:0] inst_mem [DEPTH];
  logic [A-1:0]      pc_mem   [DEPTH];

  logic pop;
  logic push;

  // A full buffer may still accept a word when the head leaves in the same cycle.
  always_comb begin
    pop  = (count != '0) & inst_ready_i;
    push = enable_i & ~redirect_i & ((count < CW'(DEPTH)) | pop);
  end

  always_ff @(posedge refresh_clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= A'(RESET_PC);
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (redirect_i) begin
      // Flush only resets bookkeeping; stale entries stay but are never valid.
      fetch_pc <= redirect_pc_i;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (push) begin
        inst_mem[wr_ptr] <= rom_data_i;
        pc_mem[wr_ptr]   <= fetch_pc;
        wr_ptr           <= wr_ptr + 1'b1;
        fetch_pc         <= fetch_pc + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rom_addr_o   = fetch_pc;
  assign inst_valid_o = (count != '0);
  assign inst_o       = inst_mem[rd_ptr];
  assign pc_o         = pc_mem[rd_ptr];
  assign count_o      = count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; ROM word at address a is 0x1000_0000 + a.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [7:0]  pc;
  logic        inst_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [1:0]  count;

  int passed;
  int total;

  fetch_ctrl #(.A(8), .W_INST(32), .DEPTH(2), .RESET_PC(0)) dut (
    .refresh_clk   (clk),
    .reset         (reset),
    .enable_i      (enable),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .inst_valid_o  (inst_valid),
    .inst_o        (inst),
    .pc_o          (pc),
    .inst_ready_i  (inst_ready),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .count_o       (count)
  );

  assign rom_data = 32'h1000_0000 + {24'h0, rom_addr};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [7:0] exp_pc, input logic [1:0] exp_cnt);
    check({tag, "_valid"}, 64'(inst_valid), 64'(1));
    check({tag, "_pc"}, 64'(pc), 64'(exp_pc));
    check({tag, "_inst"}, 64'(inst), 64'(32'h1000_0000 + {24'h0, exp_pc}));
    check({tag, "_count"}, 64'(count), 64'(exp_cnt));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 64'(inst_valid), 64'(0));
    check({tag, "_count"}, 64'(count), 64'(0));
    check({tag, "_addr"}, 64'(rom_addr), 64'(0));
    check({tag, "_inst"}, 64'(inst), 64'(0));
    check({tag, "_pc"}, 64'(pc), 64'(0));
  endtask

  initial begin
    passed      = 0;
    total       = 0;
    reset       = 1'b0;
    enable      = 1'b1;
    inst_ready  = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 8'h00;

    // Scenario 1: reset then streaming at one word per cycle
    #1 reset = 1'b1;
    #1 check_reset_state("rst1");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_head($sformatf("s1_%0d", i), 8'(i), 2'd1);
    end

    // Scenario 2: back-pressure fills the buffer, then drains in order
    reset = 1'b1;
    #1 check_reset_state("rst2");
    reset = 1'b0;
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_head("s2_full", 8'h00, 2'd2);
    check("s2_addr", 64'(rom_addr), 64'(2));
    inst_ready = 1'b1;
    tick();
    check_head("s2_d1", 8'h01, 2'd2);
    tick();
    check_head("s2_d2", 8'h02, 2'd2);

    // Scenario 3: redirect while full with a same-cycle pop
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    tick();
    redirect = 1'b0;
    check("s3_valid0", 64'(inst_valid), 64'(0));
    check("s3_addr", 64'(rom_addr), 64'(8'h40));
    check("s3_count0", 64'(count), 64'(0));
    tick();
    check_head("s3_tgt", 8'h40, 2'd1);

    // Scenario 4: PC wraps from 0xFF to 0x00
    redirect    = 1'b1;
    redirect_pc = 8'hFE;
    tick();
    redirect = 1'b0;
    check("s4_valid0", 64'(inst_valid), 64'(0));
    for (int i = 0; i < 4; i++) begin
      tick();
      check_head($sformatf("s4_%0d", i), 8'(8'hFE + i), 2'd1);
    end

    // Scenario 5: disable with two entries buffered, drain, resume
    inst_ready = 1'b0;
    tick();
    check_head("s5_fill", 8'h01, 2'd2);
    enable     = 1'b0;
    inst_ready = 1'b1;
    tick();
    check_head("s5_out2", 8'h02, 2'd1);
    check("s5_addr1", 64'(rom_addr), 64'(3));
    tick();
    check("s5_empty", 64'(inst_valid), 64'(0));
    check("s5_addr2", 64'(rom_addr), 64'(3));
    tick();
    check("s5_still", 64'(inst_valid), 64'(0));
    check("s5_addr3", 64'(rom_addr), 64'(3));
    enable = 1'b1;
    tick();
    check_head("s5_resume", 8'h03, 2'd1);

    // Scenario 6: asynchronous reset mid-stream while full
    inst_ready = 1'b0;
    tick();
    check("s6_full", 64'(count), 64'(2));
    #2 reset = 1'b1;
    #1 check("s6_valid", 64'(inst_valid), 64'(0));
    check("s6_count", 64'(count), 64'(0));
    check("s6_addr", 64'(rom_addr), 64'(0));
    reset      = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_head($sformatf("s6_%0d", i), 8'(i), 2'd1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction fetch controller that sequences the program ROM for the pico core. It owns the fetch program counter and drives the ROM address, which is a combinational read. It captures returned instruction words into a DEPTH-entry prefetch buffer and presents them to decode with a valid/ready handshake. It also handles branch/jump redirects by flushing the buffer and re-steering the fetch PC.

Parameters:
A, 8, ROM address width; the PC is a word address, so the ROM holds 2^A words.
W_INST, 32, instruction width in bits.
DEPTH, 2, prefetch buffer entries; must be a power of two and at least 2.
RESET_PC, 0, fetch PC value loaded on reset.

Ports:
refresh_clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
enable_i  input  1  fetch enable; 0 inhibits new ROM captures.
rom_addr_o  output  A  address to the ROM; always equals fetch_pc.
rom_data_i  input  W_INST  ROM read data; valid in the same cycle as rom_addr_o.
inst_valid_o  output  1  buffer head holds a valid instruction.
inst_o  output  W_INST  instruction word at the buffer head.
pc_o  output  A  PC of the instruction at the buffer head.
inst_ready_i  input  1  decode accepts the head this cycle.
redirect_i  input  1  flush the buffer and restart fetch at redirect_pc_i.
redirect_pc_i  input  A  redirect target.
count_o  output  $clog2(DEPTH)+1  number of occupied buffer entries.

Behaviour:
- Reset (asynchronous, on assertion):
  - fetch_pc = RESET_PC; count = 0; rd_ptr = wr_ptr = 0.
  - All buffer entries (inst, pc) = 0, so inst_o = 0 and pc_o = 0.
  - inst_valid_o = 0; count_o = 0.
  - Deassertion takes effect at the next rising edge.
- pop = inst_valid_o & inst_ready_i.
- push = enable_i & ~redirect_i & (count < DEPTH | pop).
  - A push is permitted when the buffer is full and popping in the same cycle, which sustains 1 instruction/cycle.
- On push:
  - entry[wr_ptr] <= {rom_data_i, fetch_pc}.
  - wr_ptr advances.
  - fetch_pc <= fetch_pc + 1, modulo 2^A; 2^A-1 wraps to 0 with no flag.
- On pop: rd_ptr advances.
- count update: count += push - pop.
- Pointers wrap modulo DEPTH.
- inst_valid_o = (count != 0).
- inst_o and pc_o are read combinationally from entry[rd_ptr]. They hold their last head contents while invalid, and entries are not cleared on flush.
- Fill latency: the first instruction at a given PC appears on inst_valid_o one cycle after the cycle in which rom_addr_o showed that PC.
- Redirect (highest priority):
  - At the edge: count = 0, rd_ptr = wr_ptr = 0, fetch_pc <= redirect_pc_i.
  - Any same-cycle push is suppressed. A same-cycle pop is still consumed by decode, but has no further effect on the buffer.
  - Cycle N+1: inst_valid_o = 0 and rom_addr_o = target.
  - Cycle N+2: the target instruction is valid, provided enable_i = 1 in N+1.
  - Redirects on consecutive cycles: the last one wins.
- enable_i = 0:
  - No push and fetch_pc holds.
  - Pops continue, so the buffer drains.
  - Redirect still updates fetch_pc and flushes.
- Full and not popping: no push, fetch_pc holds, rom_addr_o stable.
- Empty and enable_i = 1: push every cycle; no pop is possible that cycle.
- No combinational path from inst_ready_i to inst_valid_o. A path from inst_ready_i to the push decision is allowed, because the ROM is combinational.

Test Plan:
1. Reset with ROM[i] = 0x1000_0000+i, enable_i = 1, inst_ready_i = 1 -> cycle 1 onward: inst_o = 0x1000_0000, 0x1000_0001, ... one per cycle; pc_o = 0, 1, 2; count_o stays 1.
2. Back-pressure: inst_ready_i = 0 for 5 cycles after reset -> count_o reaches 2; rom_addr_o holds at 2; inst_o holds at ROM[0]. Release ready -> ROM[0], ROM[1], ROM[2] in order with no gap.
3. Redirect while full to 0x40, with inst_ready_i = 1 in the same cycle -> next cycle inst_valid_o = 0 and rom_addr_o = 0x40; following cycle pc_o = 0x40 and inst_o = ROM[0x40]; count_o = 1.
4. Wrap: redirect to 0xFE with A = 8 -> pc_o sequence 0xFE, 0xFF, 0x00, 0x01 with the matching ROM words.
5. enable_i = 0 with 2 buffered entries and ready = 1 -> 2 valid outputs, then inst_valid_o = 0; rom_addr_o frozen. Re-enable -> fetch resumes at the frozen address.
6. Reset asserted mid-stream (count = 2) between clock edges -> immediately inst_valid_o = 0, count_o = 0, rom_addr_o = RESET_PC; restart identical to scenario 1.
